// File: rtl/memory_stage_bus.sv
// rtl/memory_stage_bus.sv - pipelined memory stage: load/store over a split addr/data bus handshake
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_CHECK_EN.
module memory_stage_bus #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_pc,
  input  logic [4:0]          in_dst,
  input  logic [XLEN-1:0]     in_aluout,
  input  logic [XLEN-1:0]     in_wdata,
  input  logic                in_memread,
  input  logic                in_memwrite,
  input  logic [1:0]          in_msize,
  input  logic                in_unsigned,
  input  logic                in_regwrite,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   out_pc,
  output logic [4:0]          out_dst,
  output logic [XLEN-1:0]     out_result,
  output logic                out_regwrite,
  output logic                out_exc,
  output logic                dreq_valid,
  output logic [ADDR_W-1:0]   dreq_addr,
  output logic [2:0]          dreq_size,
  output logic [XLEN/8-1:0]   dreq_strobe,
  output logic [XLEN-1:0]     dreq_data,
  input  logic                dresp_addr_ok,
  input  logic                dresp_data_ok,
  input  logic [XLEN-1:0]     dresp_data
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pc_q;
  logic [4:0]          dst_q;
  logic                regwrite_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          msize_q;
  logic                uns_q;
  logic                store_q;
  logic [XLEN-1:0]     wdata_q;
  logic [XLEN-1:0]     result_q;

  logic                accept;
  logic                is_mem;
  logic [OFF_W-1:0]    off;
  logic [2*NB-1:0]     size_mask;
  logic [2*NB-1:0]     strobe_full;
  logic [XLEN-1:0]     sh;
  logic [63:0]         sh64;
  logic [63:0]         ext64;
  logic [XLEN-1:0]     load_result;

  assign in_ready = (state == IDLE) | ((state == OUT) & out_ready);
  assign accept   = in_valid & in_ready;
  assign is_mem   = in_memread | in_memwrite;

  assign out_valid    = (state == OUT);
  assign out_pc       = pc_q;
  assign out_dst      = dst_q;
  assign out_result   = result_q;
  assign out_regwrite = regwrite_q;

  assign off        = addr_q[OFF_W-1:0];
  assign dreq_valid = (state == REQ);
  assign dreq_addr  = addr_q;
  assign dreq_size  = {1'b0, msize_q};
  assign dreq_data  = wdata_q << {off, 3'b000};

  // Strobe mask is built double-width so bytes shifted past the bus word simply fall off.
  always_comb begin
    size_mask = '0;
    case (msize_q)
      2'd0:    size_mask = (2*NB)'(8'h01);
      2'd1:    size_mask = (2*NB)'(8'h03);
      2'd2:    size_mask = (2*NB)'(8'h0F);
      default: size_mask = (2*NB)'(8'hFF);
    endcase
    strobe_full = size_mask << off;
  end

  assign dreq_strobe = ((state == REQ) && store_q) ? strobe_full[NB-1:0] : '0;

  always_comb begin
    sh    = dresp_data >> {off, 3'b000};
    sh64  = 64'(sh);
    ext64 = sh64;
    case (msize_q)
      2'd0:    ext64 = {{56{~uns_q & sh64[7]}},  sh64[7:0]};
      2'd1:    ext64 = {{48{~uns_q & sh64[15]}}, sh64[15:0]};
      2'd2:    ext64 = {{32{~uns_q & sh64[31]}}, sh64[31:0]};
      default: ext64 = sh64;
    endcase
    load_result = ext64[XLEN-1:0];
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic exc_q;
  logic misaligned;

  always_comb begin
    misaligned = 1'b0;
    case (in_msize)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = in_aluout[0];
      2'd2:    misaligned = |in_aluout[1:0];
      default: misaligned = |in_aluout[2:0];
    endcase
  end

  assign out_exc = exc_q;
`else
  assign out_exc = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      pc_q       <= '0;
      dst_q      <= '0;
      regwrite_q <= 1'b0;
      addr_q     <= '0;
      msize_q    <= '0;
      uns_q      <= 1'b0;
      store_q    <= 1'b0;
      wdata_q    <= '0;
      result_q   <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
      exc_q      <= 1'b0;
`endif
    end else begin
      case (state)
        REQ: begin
          if (dresp_addr_ok) begin
            if (dresp_data_ok) begin
              if (!store_q) result_q <= load_result;
              state <= OUT;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dresp_data_ok) begin
            if (!store_q) result_q <= load_result;
            state <= OUT;
          end
        end
        OUT: begin
          if (out_ready && !in_valid) state <= IDLE;
        end
        default: ;
      endcase

      // Accept overrides the transitions above; OUT can refill in the same cycle it drains.
      if (accept) begin
        pc_q       <= in_pc;
        dst_q      <= in_dst;
        addr_q     <= ADDR_W'(in_aluout);
        msize_q    <= in_msize;
        uns_q      <= in_unsigned;
        store_q    <= in_memwrite;
        wdata_q    <= in_wdata;
        result_q   <= in_aluout;
        regwrite_q <= in_regwrite & ~in_memwrite;
`ifdef MEM_MISALIGN_CHECK_EN
        exc_q      <= 1'b0;
`endif
        if (!is_mem) begin
          state <= OUT;
        end
`ifdef MEM_MISALIGN_CHECK_EN
        else if (misaligned) begin
          exc_q      <= 1'b1;
          regwrite_q <= 1'b0;
          state      <= OUT;
        end
`endif
        else begin
          state <= REQ;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_stage_bus.sv
// tb/tb_memory_stage_bus.sv - randomized self-checking bench for memory_stage_bus
module tb_memory_stage_bus;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready;
  logic [63:0] in_pc, in_aluout, in_wdata;
  logic [4:0]  in_dst;
  logic        in_memread, in_memwrite, in_unsigned, in_regwrite;
  logic [1:0]  in_msize;
  logic        out_valid, out_ready;
  logic [63:0] out_pc, out_result;
  logic [4:0]  out_dst;
  logic        out_regwrite, out_exc;
  logic        dreq_valid;
  logic [63:0] dreq_addr, dreq_data;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [63:0] dresp_data;

  int checks = 0;
  int failures = 0;

  logic [63:0] last_result, last_data;
  logic [7:0]  last_strobe;
  logic [2:0]  last_size;
  logic        last_regwrite, last_exc;

`ifdef MEM_MISALIGN_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  memory_stage_bus dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_dst(in_dst),
    .in_aluout(in_aluout), .in_wdata(in_wdata), .in_memread(in_memread),
    .in_memwrite(in_memwrite), .in_msize(in_msize), .in_unsigned(in_unsigned),
    .in_regwrite(in_regwrite),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_dst(out_dst),
    .out_result(out_result), .out_regwrite(out_regwrite), .out_exc(out_exc),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] load_fmt(input logic [63:0] word, input logic [63:0] addr,
                                           input int msize, input bit uns);
    int          nbits;
    logic [63:0] mask, v;
    nbits = 8 << msize;
    mask  = (nbits == 64) ? '1 : ((64'd1 << nbits) - 64'd1);
    v     = (word >> (8 * int'(addr[2:0]))) & mask;
    if (!uns && v[nbits-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [7:0] strobe_of(input logic [63:0] addr, input int msize);
    int s;
    s = ((1 << (1 << msize)) - 1) << int'(addr[2:0]);
    return 8'(s & 'hFF);
  endfunction

  // kind: 0 ALU, 1 load, 2 store. Called and returns at a negedge.
  task automatic run_op(input int kind, input logic [63:0] addr, input int msize, input bit uns,
                        input logic [63:0] wdata, input logic [63:0] word,
                        input int a_dly, input int d_dly, input int o_dly);
    bit          is_mem, st, exc, rw;
    logic [63:0] pc, exp_res;
    logic [4:0]  dst;
    int          n;
    is_mem = (kind != 0);
    st     = (kind == 2);
    exc    = CHK_EN && is_mem && ((addr % (64'd1 << msize)) != 0);
    rw     = 1'($urandom_range(0, 1));
    pc     = {$urandom, $urandom};
    dst    = 5'($urandom);
    if (exc || kind == 0 || st) exp_res = addr;
    else exp_res = load_fmt(word, addr, msize, uns);
    last_strobe = '0; last_data = '0; last_size = '0;

    in_valid = 1'b1; in_pc = pc; in_dst = dst; in_aluout = addr; in_wdata = wdata;
    in_memread = (kind == 1); in_memwrite = st; in_msize = 2'(msize);
    in_unsigned = uns; in_regwrite = rw; out_ready = 1'b0;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) chk("accept_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;

    if (is_mem && !exc) begin
      for (int i = 0; i <= a_dly; i++) begin
        chk("req_valid", {63'd0, dreq_valid}, 64'd1);
        chk("req_addr", dreq_addr, addr);
        chk("req_size", {61'd0, dreq_size}, 64'(msize));
        chk("req_strobe", {56'd0, dreq_strobe}, st ? {56'd0, strobe_of(addr, msize)} : 64'd0);
        if (st) chk("req_data", dreq_data, wdata << (8 * int'(addr[2:0])));
        if (i == 0) begin
          last_strobe = dreq_strobe; last_data = dreq_data; last_size = dreq_size;
        end
        if (i == a_dly) begin
          dresp_addr_ok = 1'b1;
          dresp_data_ok = (d_dly == 0);
          dresp_data    = (d_dly == 0) ? word : {$urandom, $urandom};
        end else begin
          dresp_addr_ok = 1'b0;
          dresp_data_ok = 1'($urandom_range(0, 1));
          dresp_data    = {$urandom, $urandom};
        end
        @(negedge clk);
      end
      dresp_addr_ok = 1'b0;
      dresp_data_ok = 1'b0;
      for (int i = 1; i <= d_dly; i++) begin
        chk("wait_valid", {63'd0, dreq_valid}, 64'd0);
        chk("wait_out_valid", {63'd0, out_valid}, 64'd0);
        dresp_data_ok = (i == d_dly);
        dresp_data    = (i == d_dly) ? word : {$urandom, $urandom};
        @(negedge clk);
      end
      dresp_data_ok = 1'b0;
    end else begin
      chk("no_req", {63'd0, dreq_valid}, 64'd0);
    end

    for (int i = 0; i <= o_dly; i++) begin
      chk("out_valid", {63'd0, out_valid}, 64'd1);
      chk("out_result", out_result, exp_res);
      chk("out_regwrite", {63'd0, out_regwrite}, {63'd0, rw && !st && !exc});
      chk("out_exc", {63'd0, out_exc}, {63'd0, exc});
      chk("out_pc", out_pc, pc);
      chk("out_dst", {59'd0, out_dst}, {59'd0, dst});
      if (i == 0) begin
        last_result = out_result; last_regwrite = out_regwrite; last_exc = out_exc;
      end
      if (i < o_dly) begin
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
      end
    end
    out_ready = 1'b1;
    #1;
    chk("drain_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_out_valid", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    logic [63:0] b2b [3];
    b2b[0] = 64'h11; b2b[1] = 64'h22; b2b[2] = 64'h33;

    resetn = 1'b0; in_valid = 1'b0; in_pc = '0; in_dst = '0; in_aluout = '0; in_wdata = '0;
    in_memread = 1'b0; in_memwrite = 1'b0; in_msize = '0; in_unsigned = 1'b0; in_regwrite = 1'b0;
    out_ready = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
    chk("rst_dreq_strobe", {56'd0, dreq_strobe}, 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_exc", {63'd0, out_exc}, 64'd0);
    chk("rst_out_regwrite", {63'd0, out_regwrite}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    resetn = 1'b1;
    @(negedge clk);

    run_op(1, 64'h1003, 0, 1'b0, 64'd0, 64'h00000000_80000000, 0, 0, 0);
    chk("lb_signed", last_result, 64'hFFFFFFFF_FFFFFF80);
    run_op(1, 64'h1003, 0, 1'b1, 64'd0, 64'h00000000_80000000, 0, 0, 0);
    chk("lb_unsigned", last_result, 64'h80);

    run_op(2, 64'h1006, 1, 1'b0, 64'hBEEF, {$urandom, $urandom}, 0, 0, 0);
    chk("sh_strobe", {56'd0, last_strobe}, 64'hC0);
    chk("sh_data", last_data, 64'hBEEF0000_00000000);
    chk("sh_size", {61'd0, last_size}, 64'd1);
    chk("sh_regwrite", {63'd0, last_regwrite}, 64'd0);

    run_op(1, 64'h1010, 2, 1'b0, 64'd0, 64'h12345678_9ABCDEF0, 2, 3, 4);
    chk("split_lw", last_result, 64'hFFFFFFFF_9ABCDEF0);

    run_op(2, 64'h1002, 2, 1'b0, 64'hCAFEF00D, {$urandom, $urandom}, 0, 0, 0);
`ifdef MEM_MISALIGN_CHECK_EN
    chk("misalign_exc", {63'd0, last_exc}, 64'd1);
`else
    chk("misalign_strobe", {56'd0, last_strobe}, 64'h3C);
`endif

    // Reset while a request is outstanding.
    in_valid = 1'b1; in_memread = 1'b1; in_memwrite = 1'b0; in_aluout = 64'h1000; in_msize = 2'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("midreq_valid", {63'd0, dreq_valid}, 64'd1);
    resetn = 1'b0;
    #1;
    chk("midreq_rst_dreq", {63'd0, dreq_valid}, 64'd0);
    chk("midreq_rst_out", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("midreq_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);

    // Back-to-back ALU ops at full throughput.
    in_memread = 1'b0; in_memwrite = 1'b0; in_regwrite = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_aluout = b2b[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b_valid", {63'd0, out_valid}, 64'd1);
      chk("b2b_result", out_result, b2b[i]);
      chk("b2b_in_ready", {63'd0, in_ready}, 64'd1);
      if (i < 2) in_aluout = b2b[i+1];
      else in_valid = 1'b0;
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_idle", {63'd0, out_valid}, 64'd0);

    for (int k = 0; k < 80; k++) begin
      int          kind, ms;
      logic [63:0] a;
      kind = $urandom_range(0, 2);
      ms   = $urandom_range(0, 3);
      a    = 64'h2000 + 64'($urandom_range(0, 255));
      run_op(kind, a, ms, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_stage_bus.md
Name: memory_stage_bus

Overview:
- Pipelined memory stage: takes one execute-stage result per handshake and performs load/store over the data bus (dreq/dresp split address/data handshake).
- Formats load data (byte/half/word/double, sign- or zero-extended) and aligns store data/strobes.
- Presents a registered result to writeback with valid/ready backpressure.
- ALU-only instructions pass through at one per cycle.

Parameters:
- XLEN, 64, datapath/register width; must be 32 or 64.
- ADDR_W, 64, bus address width.
- OFF_W, $clog2(XLEN/8), byte-offset bits within a bus word; derived, not overridden.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  execute result valid
- in_ready  out  1  stage can accept
- in_pc  in  ADDR_W  instruction PC
- in_dst  in  5  destination register
- in_aluout  in  XLEN  ALU result; effective address for memory ops
- in_wdata  in  XLEN  store source (rs2)
- in_memread  in  1  load
- in_memwrite  in  1  store (never both)
- in_msize  in  2  0=B 1=H 2=W 3=D (3 illegal when XLEN=32)
- in_unsigned  in  1  zero-extend load
- in_regwrite  in  1  writes rd
- out_valid  out  1  result valid
- out_ready  in  1  writeback accepts
- out_pc  out  ADDR_W; out_dst  out  5; out_result  out  XLEN; out_regwrite  out  1
- out_exc  out  1  misaligned-access flag
- dreq_valid  out  1; dreq_addr  out  ADDR_W; dreq_size  out  3; dreq_strobe  out  XLEN/8 (0 = read); dreq_data  out  XLEN
- dresp_addr_ok  in  1; dresp_data_ok  in  1; dresp_data  in  XLEN

Behaviour:
- States: IDLE, REQ, WAIT, OUT. Async reset -> IDLE; all out_* = 0, dreq_valid = 0, dreq_strobe = 0, internal regs cleared. dreq_valid decodes from state, so reset drops it immediately, even mid-transaction.
- in_ready = (IDLE) | (OUT & out_ready). out_valid = (OUT).
- Accept (in_valid & in_ready):
  - Latch pc, dst, regwrite, address, size, unsigned, store data.
  - Non-memory op -> OUT, out_result = in_aluout.
  - Memory op -> REQ.
- REQ: dreq_valid = 1; addr/size/strobe/data held stable until dresp_addr_ok.
  - addr_ok & data_ok same cycle -> OUT.
  - addr_ok alone -> WAIT.
- WAIT: dreq_valid = 0. Leave on dresp_data_ok -> OUT. data_ok is ignored in IDLE and in REQ without addr_ok.
- OUT: holds all outputs stable until out_ready.
  - out_ready & in_valid: accept next op same cycle, branch as on accept (back-to-back ALU ops give throughput 1).
  - out_ready & !in_valid -> IDLE.
- Latency: ALU op 1 cycle accept->out_valid. Memory op >= 2 cycles (accept, REQ, OUT with same-cycle addr_ok/data_ok).
- Address/size: dreq_addr = full address (not word-aligned); dreq_size = {0, msize}; off = addr[OFF_W-1:0].
- Store: dreq_data = wdata << (8*off); dreq_strobe = ((1<<(1<<msize)) - 1) << off, truncated to XLEN/8 bits. Load: strobe = 0.
- Load: sh = dresp_data >> (8*off). Low 8/16/32/64 bits per msize, sign-extended unless in_unsigned, into out_result. Captured in the data_ok cycle.
- Store result: out_result = address; out_regwrite forced 0.

Optional Feature:
- Macro MEM_MISALIGN_CHECK_EN.
- Defined: a memory op whose address is not a multiple of its size skips the bus (accept -> OUT directly) with out_exc = 1, out_regwrite = 0, out_result = address.
- Undefined: no check; out_exc tied 0; misaligned ops issue normally (strobe bits past the word are truncated).

Test Plan:
- Reset mid-REQ: assert resetn=0 while dreq_valid=1 -> dreq_valid=0 same cycle, out_valid=0; after release in_ready=1.
- Back-to-back ALU ops: in_aluout 0x11, 0x22, 0x33 with out_ready=1 -> out_result 0x11, 0x22, 0x33 on consecutive cycles; in_ready stays 1.
- LB at 0x1003, dresp_data 0x00000000_80000000 -> out_result 0xFFFFFFFF_FFFFFF80. Same access with in_unsigned=1 -> 0x80.
- SH addr 0x1006, wdata 0xBEEF -> dreq_strobe 0xC0, dreq_data 0xBEEF0000_00000000, dreq_size 1; out_regwrite=0.
- Split handshake: addr_ok 2 cycles after REQ entry, data_ok 3 cycles later -> dreq fields stable throughout REQ, dreq_valid=0 in WAIT. With out_ready=0 for 4 cycles, out_* held and in_ready=0.
- MEM_MISALIGN_CHECK_EN defined: LW at 0x1002 -> no dreq_valid, out_exc=1 one cycle after accept. Undefined: request issued with strobe 0x3C.
